// File: rtl/vx_tensor_uop_sequencer_if.sv
// vx_tensor_uop_sequencer_if: macro-op in, uop out and commit-return bundle for the tensor uop sequencer.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

interface vx_tensor_uop_sequencer_if #(
    parameter int NR_BITS = `NR_BITS
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [`UUID_WIDTH-1:0]    in_uuid;
    logic [`NW_WIDTH-1:0]      in_wid;
    logic [`NUM_THREADS-1:0]   in_tmask;
    logic [`XLEN-1:0]          in_pc;
    logic [NR_BITS-1:0]        in_rd, in_rs1, in_rs2, in_rs3;
    logic                      out_valid;
    logic                      out_ready;
    logic [`UUID_WIDTH-1:0]    out_uuid;
    logic [`NW_WIDTH-1:0]      out_wid;
    logic [`NUM_THREADS-1:0]   out_tmask;
    logic [`XLEN-1:0]          out_pc;
    logic [NR_BITS-1:0]        out_rd, out_rs1, out_rs2, out_rs3;
    logic                      out_wb;
    logic [1:0]                out_op_type;
    logic [`INST_MOD_BITS-1:0] out_op_mod;
    logic                      commit_fire;
    logic [`NW_WIDTH-1:0]      commit_wid;

    modport master (
        output in_valid, in_uuid, in_wid, in_tmask, in_pc, in_rd, in_rs1, in_rs2, in_rs3,
        input  in_ready,
        input  out_valid, out_uuid, out_wid, out_tmask, out_pc, out_rd, out_rs1, out_rs2, out_rs3,
        input  out_wb, out_op_type, out_op_mod,
        output out_ready, commit_fire, commit_wid
    );

    modport slave (
        input  in_valid, in_uuid, in_wid, in_tmask, in_pc, in_rd, in_rs1, in_rs2, in_rs3,
        output in_ready,
        output out_valid, out_uuid, out_wid, out_tmask, out_pc, out_rd, out_rs1, out_rs2, out_rs3,
        output out_wb, out_op_type, out_op_mod,
        input  out_ready, commit_fire, commit_wid
    );
endinterface

// File: rtl/vx_tensor_uop_sequencer.sv
// vx_tensor_uop_sequencer: expands an HMMA macro-op into NUM_STEPS x 2 tensor uops under per-warp credits.
// Optional perf counters enabled by TENSOR_SEQ_PERF_EN.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_tensor_uop_sequencer #(
    parameter int NUM_WARPS = `NUM_WARPS,
    parameter int NUM_STEPS = 4,
    parameter int CREDITS   = 4,
    parameter int NR_BITS   = `NR_BITS
) (
    input  logic clk,
    input  logic reset,
    vx_tensor_uop_sequencer_if.slave io,
    output logic busy
`ifdef TENSOR_SEQ_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0] perf_uops,
    output logic [`PERF_CTR_BITS-1:0] perf_macro,
    output logic [`PERF_CTR_BITS-1:0] perf_credit_stall
`endif
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int NW = `NW_WIDTH;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state;
    logic [1:0]              step;
    logic                    pair;
    logic [`UUID_WIDTH-1:0]  uuid;
    logic [NW-1:0]           wid;
    logic [`NUM_THREADS-1:0] tmask;
    logic [`XLEN-1:0]        pc;
    logic [NR_BITS-1:0]      rd, rs1, rs2, rs3;
    logic [CW-1:0]           credits [NUM_WARPS];
    logic                    has_credit, fire, last, accept;

    assign has_credit     = credits[wid] != '0;
    assign io.out_valid   = state == ISSUE && has_credit;
    assign fire           = io.out_valid && io.out_ready;
    assign accept         = state == IDLE && io.in_valid;
    assign last           = step == 2'(NUM_STEPS - 1) && pair;
    assign io.out_uuid    = uuid;
    assign io.out_wid     = wid;
    assign io.out_tmask   = tmask;
    assign io.out_pc      = pc;
    assign io.out_rd      = rd + NR_BITS'(pair);
    assign io.out_rs1     = rs1 + NR_BITS'(pair);
    assign io.out_rs2     = rs2 + NR_BITS'(pair);
    // Steps after the first accumulate into D, so C comes from rd.
    assign io.out_rs3     = step == 2'd0 ? rs3 + NR_BITS'(pair) : rd + NR_BITS'(pair);
    assign io.out_wb      = io.out_valid;
    assign io.out_op_type = step;
    assign io.out_op_mod  = `INST_MOD_BITS'(pair);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            io.in_ready <= 1'b1;
            busy        <= 1'b0;
            step        <= '0;
            pair        <= 1'b0;
            uuid        <= '0;
            wid         <= '0;
            tmask       <= '0;
            pc          <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rs3         <= '0;
        end else if (accept) begin
            state       <= ISSUE;
            io.in_ready <= 1'b0;
            busy        <= 1'b1;
            step        <= '0;
            pair        <= 1'b0;
            uuid        <= io.in_uuid;
            wid         <= io.in_wid;
            tmask       <= io.in_tmask;
            pc          <= io.in_pc;
            rd          <= io.in_rd;
            rs1         <= io.in_rs1;
            rs2         <= io.in_rs2;
            rs3         <= io.in_rs3;
        end else if (fire) begin
            pair <= ~pair;
            step <= step + 2'(pair);
            if (last) begin
                state       <= IDLE;
                io.in_ready <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_cred
        logic [CW-1:0] cnt;
        logic          inc, dec;
        assign inc        = io.commit_fire && io.commit_wid == NW'(w);
        assign dec        = fire && wid == NW'(w);
        assign credits[w] = cnt;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= CW'(CREDITS);
            end else if (inc && !dec) begin
                assert (cnt != CW'(CREDITS));
                cnt <= cnt == CW'(CREDITS) ? cnt : cnt + 1'b1;
            end else if (dec && !inc) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef TENSOR_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_uops         <= '0;
            perf_macro        <= '0;
            perf_credit_stall <= '0;
        end else begin
            perf_uops         <= perf_uops + `PERF_CTR_BITS'(fire);
            perf_macro        <= perf_macro + `PERF_CTR_BITS'(accept);
            perf_credit_stall <= perf_credit_stall + `PERF_CTR_BITS'(state == ISSUE && !has_credit);
        end
    end
`endif
endmodule

// File: doc/vx_tensor_uop_sequencer.md
# vx_tensor_uop_sequencer

Expands one HMMA macro-op into the ordered stream of tensor-core micro-ops: 4 steps × 2 uops per step (op_type = step, op_mod = pair index, pair index 1 = last in pair). It sits between issue and the tensor-core dispatch port. It enforces per-warp credit flow control so the tensor core's per-warp pending-uop queues never overflow. Credits return on each tensor-core commit fire.

## Interface
Parameters:
- NUM_WARPS, `NUM_WARPS: warps tracked for credits.
- NUM_STEPS, 4: steps per macro-op; legal values 1, 2, 4.
- CREDITS, 4: per-warp uop queue depth in the tensor core.
- NR_BITS, `NR_BITS: register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  macro-op valid
- in_ready  out  1  macro-op accepted when high with in_valid
- in_uuid / in_wid / in_tmask / in_pc  in  `UUID_WIDTH / `NW_WIDTH / `NUM_THREADS / `XLEN  macro-op tags
- in_rd / in_rs1 / in_rs2 / in_rs3  in  NR_BITS each  base register indices
- out_valid  out  1  uop valid
- out_ready  in  1  tensor-core dispatch ready
- out_uuid / out_wid / out_tmask / out_pc  out  as input  copied tags
- out_rd / out_rs1 / out_rs2 / out_rs3  out  NR_BITS each  uop registers
- out_wb  out  1  always 1 while out_valid
- out_op_type  out  2  step index
- out_op_mod  out  `INST_MOD_BITS  pair index (0 or 1), zero-extended
- commit_fire  in  1  tensor-core commit handshake fired
- commit_wid  in  `NW_WIDTH  warp of that commit
- busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: in_ready=1. On in_valid, latch all in_* fields, clear counter {step,pair}=0, go to ISSUE.
- ISSUE: in_ready=0.
  - out_valid=1 only when credits[latched wid] > 0.
  - Once out_valid is asserted, all out_* fields are held stable until out_ready fires.
  - On fire: decrement credits[wid]; advance pair, and on pair wrap advance step.
  - When the fire is for step=NUM_STEPS-1 and pair=1, return to IDLE.
- Uop fields for (step s, pair p):
  - out_op_type = s; out_op_mod = p.
  - out_rs1 = rs1+p; out_rs2 = rs2+p; out_rd = rd+p.
  - out_rs3 = rs3+p when s=0, else rd+p (accumulate into D).
  - All register adds wrap modulo 2^NR_BITS.
- Credits: one counter per warp, width clog2(CREDITS+1), reset to CREDITS.
  - Increment on commit_fire for commit_wid.
  - When issue and return hit the same warp in the same cycle, the net change is 0.
  - A return that would exceed CREDITS saturates at CREDITS and fires a runtime assertion.
- Pair atomicity: a stall for lack of credit may occur between uop 0 and uop 1 of a pair. Uops of a macro-op are never reordered, and no other macro-op is interleaved.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, all out_* fields 0, counter 0, credits=CREDITS.
- Macro-op accepted at cycle N → first uop valid at cycle N+1, provided a credit is available.
- With out_ready held high and credits available, one uop per cycle: uops at N+1..N+8, state IDLE at N+9. Throughput is one macro-op per 2·NUM_STEPS+1 cycles.
- in_ready depends only on state. There is no combinational path from out_ready or commit_fire to in_ready.
- out_valid may depend combinationally on the credit counter register, never on commit_fire in the same cycle. A credit returned at cycle T enables out_valid at T+1.
- Reset mid-ISSUE discards the macro-op and restores all credits immediately.

## Configuration
- TENSOR_SEQ_PERF_EN defined: adds three `PERF_CTR_BITS counters, all reset to 0, exposed on output perf_uops / perf_macro / perf_credit_stall.
  - perf_uops counts uop fires.
  - perf_macro counts macro-op accepts.
  - perf_credit_stall counts ISSUE cycles with credits[wid]=0.
- TENSOR_SEQ_PERF_EN undefined: these counters and ports are absent, and behaviour is otherwise identical.

## Test plan
- Single macro-op: wid=2, rd=8, rs1=16, rs2=24, rs3=32, out_ready=1.
  - Expect 8 uops at cycles 1–8 with (op_type,op_mod) = (0,0),(0,1),(1,0)…(3,1).
  - Expect rs3 = 32,33 for step 0, then 8,9; rd alternating 8,9; busy low at cycle 9.
- Credit exhaustion: CREDITS=4, no commit_fire.
  - Expect exactly 4 uops, then out_valid=0 with busy=1.
  - One commit_fire for wid → exactly one more uop, starting the cycle after.
- Backpressure: out_ready toggles randomly.
  - out_* stays stable while valid && !ready; no uop is lost or duplicated.
- Simultaneous issue and commit_fire on the same warp, with credits=1 → credits stay 1 and issue continues back-to-back.
- Register wrap: rd = 2^NR_BITS−1 → uop pair 1 has out_rd=0.
- Reset asserted at uop 5 → next cycle out_valid=0, in_ready=1, all credits = CREDITS.
